thresholding_cfg_loader: RTL and testbench
==========================================

Name: thresholding_cfg_loader

Overview:
- Sequencer that loads a full threshold table into the thresholding_axi AXI-lite write port.
- Threshold values arrive on an AXI-Stream in channel-major order.
- Each value is turned into one AXI-lite write; at most one write is outstanding at a time.
- While a load is in progress, the block gates the thresholding input data stream so no sample is classified against a partially written table.

Parameters:
N, 4, output precision; 2**N-1 thresholds per channel
C, 3, number of channels
K, 9, threshold/input width, signed
C_BITS, (C<2 ? 1 : $clog2(C)), channel index width (derived)
A_BITS, C_BITS+N+2, AXI-lite address width (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  load request (level or pulse)
busy  out  1  load in progress
done  out  1  one-cycle pulse when load completes
err  out  1  sticky: any BRESP != 0 seen since last start
s_thr_tvalid  in  1  threshold stream valid
s_thr_tready  out  1  threshold stream ready
s_thr_tdata  in  K  threshold value, signed
m_axilite_AWVALID  out  1  write address valid
m_axilite_AWREADY  in  1  write address ready
m_axilite_AWADDR  out  A_BITS  write address
m_axilite_WVALID  out  1  write data valid
m_axilite_WREADY  in  1  write data ready
m_axilite_WDATA  out  32  write data
m_axilite_WSTRB  out  4  constant 4'hF
m_axilite_BVALID  in  1  response valid
m_axilite_BREADY  out  1  response ready
m_axilite_BRESP  in  2  response code
s_axis_tvalid  in  1  upstream sample valid
s_axis_tready  out  1  upstream sample ready
s_axis_tdata  in  K  upstream sample
m_axis_tvalid  out  1  sample valid to thresholding
m_axis_tready  in  1  sample ready from thresholding
m_axis_tdata  out  K  sample (pass-through)

Behaviour:
- Reset: state IDLE, channel counter c=0, index counter i=0, err=0. Reset values of outputs:
  - busy, done, s_thr_tready, AWVALID, WVALID, BREADY: 0.
  - AWADDR, WDATA: 0.
- FSM states: IDLE, FETCH, ISSUE, RESP, FIN.
- IDLE:
  - If start=1 and no stalled downstream beat (!(m_axis_tvalid && !m_axis_tready)), go to FETCH next cycle with c=0, i=0, err cleared.
  - If a beat is stalled, the request is held pending and taken on the first cycle with no stall.
- FETCH:
  - s_thr_tready=1.
  - On handshake: latch tdata and go to ISSUE.
- ISSUE:
  - AWVALID=WVALID=1.
  - AWADDR={c[C_BITS-1:0], i[N-1:0], 2'b00}.
  - WDATA = tdata sign-extended from K to 32 bits.
  - AWVALID and WVALID each drop independently after their own handshake. Address and data may be accepted in either order or in the same cycle.
  - Go to RESP when both have been accepted.
- RESP:
  - BREADY=1.
  - On BVALID: err |= (BRESP != 0).
  - Advance i. When i wraps from 2**N-2 to 0, advance c.
  - If the write was c=C-1, i=2**N-2, go to FIN; otherwise go to FETCH.
- FIN: done=1 for exactly one cycle, then IDLE.
- busy=1 in every state except IDLE.
- Data gate (combinational):
  - m_axis_tvalid = s_axis_tvalid & !busy.
  - s_axis_tready = m_axis_tready & !busy.
  - m_axis_tdata = s_axis_tdata.
  - busy never rises while a downstream beat is stalled, so AXIS valid stability holds.
- Errors do not abort a load; all C*(2**N-1) writes are always issued.
- start while busy: ignored.
- start held high in IDLE: a new load begins each time IDLE is re-entered.
- Timing with zero-wait peers and s_thr_tvalid=1:
  - 3 cycles per write (FETCH, ISSUE, RESP).
  - busy lasts 3*C*(2**N-1)+1 cycles (136 for defaults).
- Reset mid-load: everything returns to reset values on the next edge. The partial table is not completed. A new start reloads from c=0, i=0.

Test Plan:
- Defaults, always-ready peers, start pulse:
  - 45 writes, in order: addresses 0x000..0x038 (c=0), then 0x040..0x078 (c=1), then 0x080..0x0B8 (c=2).
  - busy high for 136 cycles; done pulses once; err=0.
- AWREADY accepted 3 cycles before WREADY, and the reverse: AWVALID/WVALID each drop right after their own handshake; no duplicate or missing write; RESP entered only after both are accepted.
- Threshold -5 (9'h1FB) with K=9: WDATA=32'hFFFFFFFB. Threshold 200: WDATA=32'h000000C8.
- BRESP=2'b10 on write 7:
  - err=1 from the following cycle and stays 1 through done.
  - All 45 writes still issued.
  - err clears on the next start.
- start while m_axis_tvalid=1 and m_axis_tready=0: busy stays 0 until the beat completes, rises 1 cycle later, and s_axis_tready=0 thereafter until done.
- rst asserted during write 20:
  - Next cycle all outputs are at reset values.
  - A subsequent start produces a first write at address 0x000 with the first stream value.

Source files
------------

// File: rtl/thresholding_cfg_loader.sv
// Streams a full threshold table into the thresholding AXI-lite write port,
// one write in flight at a time, and holds off the sample stream while loading.
module thresholding_cfg_loader #(
    parameter int N      = 4,
    parameter int C      = 3,
    parameter int K      = 9,
    parameter int C_BITS = (C < 2 ? 1 : $clog2(C)),
    parameter int A_BITS = C_BITS + N + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              s_thr_tvalid,
    output logic              s_thr_tready,
    input  logic [K-1:0]      s_thr_tdata,
    output logic              m_axilite_AWVALID,
    input  logic              m_axilite_AWREADY,
    output logic [A_BITS-1:0] m_axilite_AWADDR,
    output logic              m_axilite_WVALID,
    input  logic              m_axilite_WREADY,
    output logic [31:0]       m_axilite_WDATA,
    output logic [3:0]        m_axilite_WSTRB,
    input  logic              m_axilite_BVALID,
    output logic              m_axilite_BREADY,
    input  logic [1:0]        m_axilite_BRESP,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [K-1:0]      s_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [K-1:0]      m_axis_tdata
);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, RESP, FIN} state_e;

    localparam logic [N-1:0]      I_LAST = N'(2**N - 2);
    localparam logic [C_BITS-1:0] C_LAST = C_BITS'(C - 1);

    state_e              state_q, state_d;
    logic [C_BITS-1:0]   c_q, c_d;
    logic [N-1:0]        i_q, i_d;
    logic [K-1:0]        data_q, data_d;
    logic                err_q, err_d;
    logic                aw_ok_q, aw_ok_d;
    logic                w_ok_q, w_ok_d;
    logic                pend_q, pend_d;
    logic                stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            i_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            aw_ok_q <= 1'b0;
            w_ok_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            i_q     <= i_d;
            data_q  <= data_d;
            err_q   <= err_d;
            aw_ok_q <= aw_ok_d;
            w_ok_q  <= w_ok_d;
            pend_q  <= pend_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign stall = m_axis_tvalid && !m_axis_tready;

    always_comb begin
        state_d           = state_q;
        c_d               = c_q;
        i_d               = i_q;
        data_d            = data_q;
        err_d             = err_q;
        aw_ok_d           = aw_ok_q;
        w_ok_d            = w_ok_q;
        pend_d            = pend_q;
        done              = 1'b0;
        s_thr_tready      = 1'b0;
        m_axilite_AWVALID = 1'b0;
        m_axilite_WVALID  = 1'b0;
        m_axilite_BREADY  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A start seen during a stalled downstream beat waits for the beat to drain.
                if ((start || pend_q) && !stall) begin
                    state_d = FETCH;
                    c_d     = '0;
                    i_d     = '0;
                    err_d   = 1'b0;
                    pend_d  = 1'b0;
                end else if (start) begin
                    pend_d = 1'b1;
                end
            end
            FETCH: begin
                s_thr_tready = 1'b1;
                if (s_thr_tvalid) begin
                    data_d  = s_thr_tdata;
                    aw_ok_d = 1'b0;
                    w_ok_d  = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                m_axilite_AWVALID = !aw_ok_q;
                m_axilite_WVALID  = !w_ok_q;
                aw_ok_d = aw_ok_q || m_axilite_AWREADY;
                w_ok_d  = w_ok_q || m_axilite_WREADY;
                if (aw_ok_d && w_ok_d) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                m_axilite_BREADY = 1'b1;
                if (m_axilite_BVALID) begin
                    err_d = err_q || (m_axilite_BRESP != 2'b00);
                    if (i_q == I_LAST) begin
                        i_d = '0;
                        c_d = (c_q == C_LAST) ? '0 : c_q + C_BITS'(1);
                    end else begin
                        i_d = i_q + N'(1);
                    end
                    state_d = (c_q == C_LAST && i_q == I_LAST) ? FIN : FETCH;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign err              = err_q;
    assign m_axilite_AWADDR = {c_q, i_q, 2'b00};
    assign m_axilite_WDATA  = {{(32-K){data_q[K-1]}}, data_q};
    assign m_axilite_WSTRB  = 4'hF;

    assign m_axis_tvalid = s_axis_tvalid && !busy;
    assign s_axis_tready = m_axis_tready && !busy;
    assign m_axis_tdata  = s_axis_tdata;

endmodule

// File: tb/tb_thresholding_cfg_loader.sv
// Bench for thresholding_cfg_loader: stream source, AXI-lite slave and AXIS gate
// monitor around the DUT, with expected writes computed from table geometry.
module tb_thresholding_cfg_loader;

    localparam int N  = 4;
    localparam int C  = 3;
    localparam int K  = 9;
    localparam int AB = 8;
    localparam int PC = 2**N - 1;
    localparam int NW = C * PC;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, err;
    logic          s_thr_tvalid = 1'b0;
    logic          s_thr_tready;
    logic [K-1:0]  s_thr_tdata = '0;
    logic          AWVALID, AWREADY = 1'b0;
    logic [AB-1:0] AWADDR;
    logic          WVALID, WREADY = 1'b0;
    logic [31:0]   WDATA;
    logic [3:0]    WSTRB;
    logic          BVALID = 1'b0, BREADY;
    logic [1:0]    BRESP = 2'b00;
    logic          s_axis_tvalid = 1'b0, s_axis_tready;
    logic [K-1:0]  s_axis_tdata = '0;
    logic          m_axis_tvalid, m_axis_tready = 1'b1;
    logic [K-1:0]  m_axis_tdata;

    thresholding_cfg_loader #(.N(N), .C(C), .K(K)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .s_thr_tvalid(s_thr_tvalid), .s_thr_tready(s_thr_tready), .s_thr_tdata(s_thr_tdata),
        .m_axilite_AWVALID(AWVALID), .m_axilite_AWREADY(AWREADY), .m_axilite_AWADDR(AWADDR),
        .m_axilite_WVALID(WVALID), .m_axilite_WREADY(WREADY), .m_axilite_WDATA(WDATA),
        .m_axilite_WSTRB(WSTRB), .m_axilite_BVALID(BVALID), .m_axilite_BREADY(BREADY),
        .m_axilite_BRESP(BRESP), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata)
    );

    always #5 clk = ~clk;

    // Written only by the test process
    logic [K-1:0] thr_vals [NW];
    int           aw_delay = 0, w_delay = 0, bad_idx = -1, clr_gen = 0;
    bit           thr_gaps = 1'b0;
    int           vectors = 0, miscompares = 0;

    // Written only by the monitor process
    logic [AB-1:0] aw_log[$];
    logic [31:0]   w_log[$];
    int  b_cnt = 0, busy_cnt = 0, done_cnt = 0, viol = 0, thr_idx = 0, seen_gen = 0;
    int  aw_wait = 0, w_wait = 0;
    bit  b_pend = 0, thr_hold = 0, err_model = 0, bad_seen = 0, prev_busy = 0;
    bit  prev_aw_stall = 0, prev_w_stall = 0, prev_aw_hs = 0, prev_w_hs = 0;

    always @(negedge clk) begin
        if (clr_gen != seen_gen) begin
            seen_gen = clr_gen;
            aw_log.delete();
            w_log.delete();
            b_cnt = 0; busy_cnt = 0; done_cnt = 0; viol = 0; thr_idx = 0; thr_hold = 0;
        end
        if (rst) begin
            s_thr_tvalid = 1'b0; AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
            b_pend = 0; thr_hold = 0; err_model = 0; bad_seen = 0; prev_busy = 0;
            prev_aw_stall = 0; prev_w_stall = 0; prev_aw_hs = 0; prev_w_hs = 0;
            aw_wait = 0; w_wait = 0;
        end else begin
            s_thr_tvalid = (thr_idx < NW) && (thr_hold || !thr_gaps || $urandom_range(3, 0) != 0);
            s_thr_tdata  = (thr_idx < NW) ? thr_vals[thr_idx] : '0;
            AWREADY = AWVALID && (aw_wait >= aw_delay);
            WREADY  = WVALID && (w_wait >= w_delay);
            BVALID  = b_pend;
            BRESP   = (b_pend && b_cnt == bad_idx) ? 2'b10 : 2'b00;
            #1;
            // Sticky error model: cleared when a load begins, set after a bad response
            if (busy && !prev_busy) err_model = 0;
            if (bad_seen) err_model = 1;
            if (err !== err_model) viol++;
            if (prev_aw_stall && !AWVALID) viol++;
            if (prev_w_stall && !WVALID) viol++;
            if (prev_aw_hs && AWVALID) viol++;
            if (prev_w_hs && WVALID) viol++;
            if (AWVALID && aw_log.size() != b_cnt) viol++;
            if (WVALID && w_log.size() != b_cnt) viol++;
            if (BREADY && (aw_log.size() != b_cnt + 1 || w_log.size() != b_cnt + 1)) viol++;
            if (busy && (s_axis_tready || m_axis_tvalid)) viol++;
            if (!busy && (m_axis_tvalid !== s_axis_tvalid || s_axis_tready !== m_axis_tready)) viol++;
            if (m_axis_tdata !== s_axis_tdata) viol++;
            if (WSTRB !== 4'hF) viol++;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (s_thr_tvalid && s_thr_tready) begin
                thr_idx++;
                thr_hold = 0;
            end else begin
                thr_hold = s_thr_tvalid;
            end
            prev_aw_hs = AWVALID && AWREADY;
            prev_aw_stall = AWVALID && !AWREADY;
            if (prev_aw_hs) begin aw_log.push_back(AWADDR); aw_wait = 0; end
            else if (AWVALID) aw_wait++;
            prev_w_hs = WVALID && WREADY;
            prev_w_stall = WVALID && !WREADY;
            if (prev_w_hs) begin w_log.push_back(WDATA); w_wait = 0; end
            else if (WVALID) w_wait++;
            bad_seen = 0;
            if (BVALID && BREADY) begin
                bad_seen = (BRESP != 2'b00);
                b_cnt++;
            end
            b_pend = (aw_log.size() > b_cnt) && (w_log.size() > b_cnt);
            prev_busy = busy;
        end
    end

    typedef struct {
        logic [K-1:0] thr;
        logic [31:0]  wdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [K-1:0] v);
        int s = v;
        if (s >= 2**(K-1)) s -= 2**K;
        return 32'(s);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic fill_random(input int first);
        for (int w = first; w < NW; w++) thr_vals[w] = K'($urandom_range(2**K - 1, 0));
    endtask

    task automatic start_load();
        clr_gen++;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            cyc();
            seen = done;
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic check_load(input string name);
        repeat (3) cyc();
        chk({name, "_aw_count"}, aw_log.size(), NW);
        chk({name, "_w_count"}, w_log.size(), NW);
        chk({name, "_b_count"}, b_cnt, NW);
        chk({name, "_done_pulses"}, done_cnt, 1);
        chk({name, "_protocol"}, viol, 0);
        for (int w = 0; w < NW && w < aw_log.size() && w < w_log.size(); w++) begin
            chk($sformatf("%s_addr%0d", name, w), 32'(aw_log[w]), 32'((w / PC) * 64 + (w % PC) * 4));
            chk($sformatf("%s_data%0d", name, w), w_log[w], sext(thr_vals[w]));
        end
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_busy"}, 32'(busy), 0);
        chk({name, "_done"}, 32'(done), 0);
        chk({name, "_err"}, 32'(err), 0);
        chk({name, "_thr_tready"}, 32'(s_thr_tready), 0);
        chk({name, "_awvalid"}, 32'(AWVALID), 0);
        chk({name, "_wvalid"}, 32'(WVALID), 0);
        chk({name, "_bready"}, 32'(BREADY), 0);
        chk({name, "_awaddr"}, 32'(AWADDR), 0);
        chk({name, "_wdata"}, WDATA, 0);
    endtask

    initial begin
        vec_t tbl [6];
        bit   hit;
        tbl = '{'{9'h1FB, 32'hFFFFFFFB}, '{9'd200, 32'h000000C8}, '{9'h000, 32'h0},
                '{9'h0FF, 32'h000000FF}, '{9'h100, 32'hFFFFFF00}, '{9'h1FF, 32'hFFFFFFFF}};

        cyc();
        chk_reset("reset");
        rst = 1'b0;
        cyc();

        // Zero-wait load with sign-extension vectors at the head of the stream
        for (int k = 0; k < 6; k++) thr_vals[k] = tbl[k].thr;
        fill_random(6);
        start_load();
        wait_done("basic");
        chk("basic_err_at_done", 32'(err), 0);
        check_load("basic");
        chk("basic_busy_cycles", busy_cnt, 3 * NW + 1);
        for (int k = 0; k < 6 && k < w_log.size(); k++)
            chk($sformatf("sext_vec%0d", k), w_log[k], tbl[k].wdata);

        // Address accepted well before data, then the reverse, with a gappy stream
        thr_gaps = 1'b1;
        aw_delay = 0; w_delay = 3;
        fill_random(0);
        start_load();
        wait_done("aw_first");
        check_load("aw_first");
        aw_delay = 3; w_delay = 0;
        fill_random(0);
        start_load();
        wait_done("w_first");
        check_load("w_first");
        aw_delay = 0; w_delay = 0; thr_gaps = 1'b0;

        // Error response on write 7 does not abort; next start clears the flag
        bad_idx = 7;
        fill_random(0);
        start_load();
        wait_done("bresp");
        chk("bresp_err_at_done", 32'(err), 1);
        check_load("bresp");
        chk("bresp_err_after_done", 32'(err), 1);
        bad_idx = -1;
        fill_random(0);
        start_load();
        cyc();
        chk("bresp_err_cleared", 32'(err), 0);
        wait_done("bresp2");
        check_load("bresp2");

        // Start during a stalled downstream beat
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = K'($urandom_range(2**K - 1, 0));
        m_axis_tready = 1'b0;
        fill_random(0);
        start_load();
        repeat (4) cyc();
        chk("stall_busy_low", 32'(busy), 0);
        chk("stall_m_tvalid", 32'(m_axis_tvalid), 1);
        m_axis_tready = 1'b1;
        chk("stall_busy_drain_cycle", 32'(busy), 0);
        cyc();
        chk("stall_busy_rises", 32'(busy), 1);
        chk("stall_s_tready_gated", 32'(s_axis_tready), 0);
        chk("stall_m_tvalid_gated", 32'(m_axis_tvalid), 0);
        wait_done("stall");
        check_load("stall");
        s_axis_tvalid = 1'b0;

        // Reset while write 20 is being issued, then reload from scratch
        fill_random(0);
        start_load();
        hit = 0;
        for (int k = 0; k < 2000 && !hit; k++) begin
            cyc();
            hit = AWVALID && (aw_log.size() == 20);
        end
        chk("midrst_reached_write20", 32'(hit), 1);
        rst = 1'b1;
        cyc();
        chk_reset("midrst");
        rst = 1'b0;
        cyc();
        fill_random(0);
        start_load();
        wait_done("reload");
        check_load("reload");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
